// File: rtl/deskew_job_ctrl.sv
// Job sequencer for the Deskew core: ping-pong BRAM bank ownership, host/core port
// arbitration, in-order job dispatch, done interrupt and a watchdog that resets a hung core.
module deskew_job_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_en,
  input  logic [3:0]        host_we,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [WIDTH-1:0]  host_rdata,
  output logic              host_bank,
  input  logic              submit,
  output logic              submit_ready,
  output logic              irq,
  input  logic              irq_ack,
  output logic              err,
  output logic              busy,
  output logic [7:0]        done_cnt,
  output logic              core_start,
  output logic              core_reset,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_en,
  input  logic [3:0]        core_we,
  input  logic [WIDTH-1:0]  core_wdata,
  output logic [WIDTH-1:0]  core_rdata,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [2:0]        state_dbg,
  output logic [1:0]        full_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_KILL  = 3'd4
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic            run_bank, act_bank;
  logic [1:0]      full, full_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            kill_cnt;
  logic            job_end, job_ok, submit_acc;

  assign submit_ready = !full[host_bank];
  assign submit_acc   = submit && submit_ready;
  assign core_start   = (state == S_START);
  assign core_reset   = (state != S_KILL);
  assign busy         = (state != S_IDLE);
  assign host_rdata   = mem_rdata;
  assign core_rdata   = mem_rdata;
  assign state_dbg    = state;
  assign full_dbg     = full;

  // The core always wins the single BRAM port; the host only touches a bank it owns.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_wdata = '0;
    mem_addr  = '0;
    host_gnt  = 1'b0;
    if (core_en) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_wdata = core_wdata;
      mem_addr  = {act_bank, core_addr};
    end else if (reset && host_en && !full[host_bank]) begin
      host_gnt  = 1'b1;
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_wdata = host_wdata;
      mem_addr  = {host_bank, host_addr};
    end
  end

  always_comb begin
    state_nxt = state;
    job_end   = 1'b0;
    job_ok    = 1'b0;
    case (state)
      S_IDLE:  if (full[run_bank] && core_ready) state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (core_done) begin
          state_nxt = S_DRAIN;
          job_end   = 1'b1;
          job_ok    = 1'b1;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          state_nxt = S_KILL;
          job_end   = 1'b1;
        end
      end
      S_DRAIN: if (!core_done && core_ready) state_nxt = S_IDLE;
      S_KILL:  if (kill_cnt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Freed bank is always act_bank, which is full, so it never collides with an accepted submit.
  always_comb begin
    full_nxt = full;
    if (job_end) full_nxt[act_bank] = 1'b0;
    if (submit_acc) full_nxt[host_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      host_bank   <= 1'b0;
      run_bank    <= 1'b0;
      act_bank    <= 1'b0;
      full        <= 2'b00;
      irq         <= 1'b0;
      err         <= 1'b0;
      done_cnt    <= 8'd0;
      wd_cnt      <= '0;
      kill_cnt    <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      state       <= state_nxt;
      full        <= full_nxt;
      host_rvalid <= host_gnt && (host_we == 4'h0);
      if (state == S_IDLE && state_nxt == S_START) act_bank <= run_bank;
      if (state == S_START) wd_cnt <= '0;
      else if (state == S_RUN) wd_cnt <= wd_cnt + 1'b1;
      kill_cnt <= (state == S_KILL) ? ~kill_cnt : 1'b0;
      if (submit_acc) host_bank <= ~host_bank;
      if (job_end) run_bank <= ~run_bank;
      if (job_ok) done_cnt <= done_cnt + 8'd1;
      // A new completion outranks an acknowledge arriving in the same cycle.
      if (job_ok) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
      if (job_end && !job_ok) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deskew_job_ctrl.sv
// Directed bench for deskew_job_ctrl: BRAM model, scripted core behaviour,
// hand-computed expectations checked after each clock edge.
module tb_deskew_job_ctrl;
  localparam int WIDTH = 16;
  localparam int ADDR_W = 13;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] host_addr;
  logic              host_en;
  logic [3:0]        host_we;
  logic [WIDTH-1:0]  host_wdata;
  logic              host_gnt, host_rvalid, host_bank;
  logic [WIDTH-1:0]  host_rdata;
  logic              submit, submit_ready, irq, irq_ack, err, busy;
  logic [7:0]        done_cnt;
  logic              core_start, core_reset, core_ready, core_done, core_en;
  logic [ADDR_W-1:0] core_addr;
  logic [3:0]        core_we;
  logic [WIDTH-1:0]  core_wdata, core_rdata;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic [2:0]        state_dbg;
  logic [1:0]        full_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] rd;

  always #5 clk = ~clk;

  deskew_job_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .host_addr(host_addr), .host_en(host_en), .host_we(host_we), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_bank(host_bank), .submit(submit), .submit_ready(submit_ready),
    .irq(irq), .irq_ack(irq_ack), .err(err), .busy(busy), .done_cnt(done_cnt),
    .core_start(core_start), .core_reset(core_reset), .core_ready(core_ready),
    .core_done(core_done), .core_addr(core_addr), .core_en(core_en), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg), .full_dbg(full_dbg)
  );

  // Single-port BRAM with one-cycle read latency.
  logic [WIDTH-1:0] mem [0:(1<<(ADDR_W+1))-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'h0) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 50) begin
      step();
      n++;
    end
    check_eq("start_seen", core_start, 1);
    core_ready = 1'b0;
    step();
    check_eq("start_pulse", core_start, 0);
  endtask

  task automatic finish_job(input int run_cycles, input bit ack, input bit sub);
    repeat (run_cycles) step();
    core_done = 1'b1;
    irq_ack   = ack;
    submit    = sub;
    step();
    irq_ack = 1'b0;
    check_eq("irq_on_done", irq, 1);
    check_eq("state_drain", state_dbg, 3);
    if (sub) begin
      check_eq("submit_refused_full", full_dbg, 2'b10);
      check_eq("submit_ready_next", submit_ready, 1);
      step();
      submit = 1'b0;
      check_eq("submit_accepted_next", full_dbg, 2'b11);
      check_eq("host_bank_after_resub", host_bank, 1);
    end
    submit = 1'b0;
    repeat (14) step();
    core_done  = 1'b0;
    core_ready = 1'b1;
    step();
    check_eq("drain_to_idle", state_dbg, 0);
  endtask

  initial begin
    reset = 1'b0; host_addr = '0; host_en = 1'b0; host_we = 4'h0; host_wdata = '0;
    submit = 1'b0; irq_ack = 1'b0; core_ready = 1'b1; core_done = 1'b0;
    core_addr = '0; core_en = 1'b0; core_we = 4'h0; core_wdata = '0;

    // Reset values
    do_reset();
    check_eq("rst_state", state_dbg, 0);
    check_eq("rst_host_bank", host_bank, 0);
    check_eq("rst_full", full_dbg, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_done_cnt", done_cnt, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rvalid", host_rvalid, 0);
    check_eq("rst_submit_ready", submit_ready, 1);

    // Job 1: fill bank 0 with 784 pixels, read some back, run it
    host_en = 1'b1;
    host_we = 4'hF;
    for (int i = 0; i < 784; i++) begin
      host_addr  = ADDR_W'(i * 4);
      host_wdata = WIDTH'(16'h1000 + i);
      step();
    end
    host_we = 4'h0;
    host_addr = ADDR_W'(0);
    step();
    check_eq("rd0_rvalid", host_rvalid, 1);
    check_eq("rd0_data", host_rdata, 16'h1000);
    host_addr = ADDR_W'(783 * 4);
    step();
    host_en = 1'b0;
    check_eq("rd783_data", host_rdata, 16'h1000 + 783);
    step();
    check_eq("rvalid_drop", host_rvalid, 0);

    submit = 1'b1;
    step();
    submit = 1'b0;
    check_eq("t1_host_bank", host_bank, 1);
    check_eq("t1_full", full_dbg, 2'b01);
    wait_start();

    // Core owns the port while core_en is high
    core_en = 1'b1; core_addr = ADDR_W'(5); host_en = 1'b1; host_addr = ADDR_W'(7);
    #1;
    check_eq("arb_host_blocked", host_gnt, 0);
    check_eq("arb_core_addr", mem_addr, {1'b0, 13'd5});
    core_en = 1'b0;
    #1;
    check_eq("arb_host_gnt", host_gnt, 1);
    check_eq("arb_host_addr", mem_addr, {1'b1, 13'd7});
    host_en = 1'b0;

    finish_job(20, 1'b0, 1'b0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_full_end", full_dbg, 2'b00);
    check_eq("t1_irq_held", irq, 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("t1_lone_ack", irq, 0);

    // Back-to-back submits into banks 0 and 1
    do_reset();
    submit = 1'b1;
    step();
    check_eq("t2_first_submit", full_dbg, 2'b01);
    step();
    submit = 1'b0;
    check_eq("t2_both_full", full_dbg, 2'b11);
    check_eq("t2_submit_ready", submit_ready, 0);
    check_eq("t2_host_bank", host_bank, 0);
    host_en = 1'b1;
    #1;
    check_eq("t2_host_full_gnt", host_gnt, 0);
    check_eq("t2_host_full_mem_en", mem_en, 0);
    host_en = 1'b0;
    wait_start();
    finish_job(30, 1'b0, 1'b1);
    check_eq("t2_done_cnt1", done_cnt, 1);
    wait_start();
    finish_job(30, 1'b1, 1'b0);
    check_eq("t2_done_cnt2", done_cnt, 2);
    check_eq("t2_full_after_job1", full_dbg, 2'b01);
    wait_start();
    finish_job(10, 1'b0, 1'b0);
    check_eq("t2_done_cnt3", done_cnt, 3);
    check_eq("t2_full_end", full_dbg, 2'b00);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_eq("t2_lone_ack", irq, 0);

    // Watchdog: core never finishes, job in bank 1
    submit = 1'b1;
    step();
    submit = 1'b0;
    check_eq("t4_full", full_dbg, 2'b10);
    wait_start();
    core_en = 1'b1; core_addr = ADDR_W'(9);
    #1;
    check_eq("t4_act_bank", mem_addr[ADDR_W], 1);
    core_en = 1'b0;
    repeat (63) step();
    check_eq("t4_err_before", err, 0);
    check_eq("t4_still_run", state_dbg, 2);
    step();
    check_eq("t4_err_set", err, 1);
    check_eq("t4_core_reset_lo1", core_reset, 0);
    check_eq("t4_bank_freed", full_dbg, 2'b00);
    check_eq("t4_no_irq", irq, 0);
    step();
    check_eq("t4_core_reset_lo2", core_reset, 0);
    step();
    check_eq("t4_core_reset_hi", core_reset, 1);
    check_eq("t4_idle", state_dbg, 0);
    check_eq("t4_done_cnt", done_cnt, 3);
    check_eq("t4_err_sticky", err, 1);
    core_ready = 1'b1;

    // Reset in the middle of a run
    submit = 1'b1;
    step();
    submit = 1'b0;
    wait_start();
    repeat (5) step();
    check_eq("t6_running", state_dbg, 2);
    reset = 1'b0;
    step();
    check_eq("t6_state", state_dbg, 0);
    check_eq("t6_full", full_dbg, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_done_cnt", done_cnt, 0);
    check_eq("t6_host_bank", host_bank, 0);
    check_eq("t6_core_reset", core_reset, 1);
    check_eq("t6_core_start", core_start, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_irq", irq, 0);
    reset = 1'b1;
    core_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
